// File: rtl/structure_tensor_accum_pipe.sv
// structure_tensor_accum_pipe: 3-stage WIN x WIN box-sum accumulator of the five structure-tensor products
// Stage 1 forms the products, stage 2 builds column sums from line buffers, stage 3 keeps running row sums.
module structure_tensor_accum_pipe #(
    parameter int WIDTH       = 320,
    parameter int HEIGHT      = 240,
    parameter int GRAD_WIDTH  = 12,
    parameter int WIN         = 5,
    parameter int ACCUM_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic signed [GRAD_WIDTH-1:0]  grad_x,
    input  logic signed [GRAD_WIDTH-1:0]  grad_y,
    input  logic signed [GRAD_WIDTH-1:0]  grad_t,
    input  logic                          grad_valid,
    input  logic                          sof,
    output logic signed [ACCUM_WIDTH-1:0] sum_IxIx,
    output logic signed [ACCUM_WIDTH-1:0] sum_IyIy,
    output logic signed [ACCUM_WIDTH-1:0] sum_IxIy,
    output logic signed [ACCUM_WIDTH-1:0] sum_IxIt,
    output logic signed [ACCUM_WIDTH-1:0] sum_IyIt,
    output logic                          accum_valid,
    output logic [$clog2(WIDTH)-1:0]      out_x,
    output logic [$clog2(HEIGHT)-1:0]     out_y
);
    localparam int PW = 2 * GRAD_WIDTH;
    localparam int AW = ACCUM_WIDTH;
    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam int NC = 5;

    if (ACCUM_WIDTH < PW + $clog2(WIN * WIN)) begin : g_aw_chk
        $error("ACCUM_WIDTH too narrow for a WIN x WIN sum of products");
    end
    if (WIN < 3 || WIN > 9 || WIN % 2 == 0) begin : g_win_chk
        $error("WIN must be odd and within 3..9");
    end

    logic [XW-1:0] x_cnt, cur_x, s1_x, s2_x;
    logic [YW-1:0] y_cnt, cur_y, s1_y, s2_y;
    logic          s1_valid, s2_valid, hit;
    logic signed [PW-1:0] s1_p [NC];
    logic signed [PW-1:0] lb [NC][WIN-1][WIDTH];
    logic signed [AW-1:0] col [NC];
    logic signed [AW-1:0] s2_col [NC];
    logic signed [AW-1:0] sr [NC][WIN];
    logic signed [AW-1:0] row_sum [NC];
    logic signed [AW-1:0] row_next [NC];
    logic signed [AW-1:0] sum_q [NC];

    assign cur_x = sof ? '0 : x_cnt;
    assign cur_y = sof ? '0 : y_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (grad_valid) begin
            x_cnt <= (cur_x == XW'(WIDTH - 1)) ? '0 : cur_x + XW'(1);
            y_cnt <= (cur_x != XW'(WIDTH - 1)) ? cur_y :
                     (cur_y == YW'(HEIGHT - 1)) ? '0 : cur_y + YW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_x     <= '0;
            s1_y     <= '0;
            for (int c = 0; c < NC; c++) s1_p[c] <= '0;
        end else begin
            s1_valid <= grad_valid;
            if (grad_valid) begin
                s1_x    <= cur_x;
                s1_y    <= cur_y;
                s1_p[0] <= PW'(grad_x) * PW'(grad_x);
                s1_p[1] <= PW'(grad_y) * PW'(grad_y);
                s1_p[2] <= PW'(grad_x) * PW'(grad_y);
                s1_p[3] <= PW'(grad_x) * PW'(grad_t);
                s1_p[4] <= PW'(grad_y) * PW'(grad_t);
            end
        end
    end

    // lb[c][k] holds the product from k+1 rows above; RAM contents are never reset
    always_ff @(posedge clk) begin
        if (s1_valid) begin
            for (int c = 0; c < NC; c++) begin
                lb[c][0][s1_x] <= s1_p[c];
                for (int k = 1; k < WIN - 1; k++) lb[c][k][s1_x] <= lb[c][k-1][s1_x];
            end
        end
    end

    always_comb begin
        for (int c = 0; c < NC; c++) begin
            col[c] = AW'(s1_p[c]);
            for (int k = 0; k < WIN - 1; k++) col[c] = col[c] + AW'(lb[c][k][s1_x]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_x     <= '0;
            s2_y     <= '0;
            for (int c = 0; c < NC; c++) s2_col[c] <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_x <= s1_x;
                s2_y <= s1_y;
                for (int c = 0; c < NC; c++) s2_col[c] <= col[c];
            end
        end
    end

    always_comb begin
        for (int c = 0; c < NC; c++)
            row_next[c] = (s2_x == '0) ? s2_col[c] : row_sum[c] + s2_col[c] - sr[c][WIN-1];
    end

    assign hit = s2_valid && s2_x >= XW'(WIN - 1) && s2_y >= YW'(WIN - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            accum_valid <= 1'b0;
            out_x       <= '0;
            out_y       <= '0;
            for (int c = 0; c < NC; c++) begin
                row_sum[c] <= '0;
                sum_q[c]   <= '0;
                for (int k = 0; k < WIN; k++) sr[c][k] <= '0;
            end
        end else begin
            accum_valid <= hit;
            if (s2_valid) begin
                for (int c = 0; c < NC; c++) begin
                    row_sum[c] <= row_next[c];
                    sr[c][0]   <= s2_col[c];
                    for (int k = 1; k < WIN; k++) sr[c][k] <= (s2_x == '0) ? '0 : sr[c][k-1];
                end
            end
            if (hit) begin
                out_x <= s2_x;
                out_y <= s2_y;
                for (int c = 0; c < NC; c++) sum_q[c] <= row_next[c];
            end
        end
    end

    assign sum_IxIx = sum_q[0];
    assign sum_IyIy = sum_q[1];
    assign sum_IxIy = sum_q[2];
    assign sum_IxIt = sum_q[3];
    assign sum_IyIt = sum_q[4];
endmodule

// File: tb/tb_structure_tensor_accum_pipe.sv
// tb_structure_tensor_accum_pipe: directed frames into the accumulator, scoreboard of expected window sums
// Expectations are queued at issue time; a negedge monitor pops them whenever accum_valid is seen.
module tb_structure_tensor_accum_pipe;
    localparam int W  = 16;
    localparam int H  = 8;
    localparam int GW = 12;
    localparam int WN = 5;
    localparam int AW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic signed [GW-1:0] grad_x = '0, grad_y = '0, grad_t = '0;
    logic grad_valid = 1'b0, sof = 1'b0;
    logic signed [AW-1:0] s_xx, s_yy, s_xy, s_xt, s_yt;
    logic accum_valid;
    logic [3:0] out_x;
    logic [2:0] out_y;

    typedef struct {int x; int y; int xx; int yy; int xy; int xt; int yt; longint cyc;} exp_t;

    exp_t q[$];
    exp_t hold_e, m_e, kc;
    int total = 0, bad = 0, pulses = 0;
    longint cyc = 0;
    int gx[H][W], gy[H][W], gt[H][W];

    structure_tensor_accum_pipe #(.WIDTH(W), .HEIGHT(H), .GRAD_WIDTH(GW), .WIN(WN), .ACCUM_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .grad_x(grad_x), .grad_y(grad_y), .grad_t(grad_t),
        .grad_valid(grad_valid), .sof(sof),
        .sum_IxIx(s_xx), .sum_IyIy(s_yy), .sum_IxIy(s_xy), .sum_IxIt(s_xt), .sum_IyIt(s_yt),
        .accum_valid(accum_valid), .out_x(out_x), .out_y(out_y)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (accum_valid) begin
                pulses++;
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pulse: got output at (%0d,%0d) expected none", out_x, out_y);
                end else begin
                    m_e = q.pop_front();
                    chk("out_x", longint'(out_x), m_e.x);
                    chk("out_y", longint'(out_y), m_e.y);
                    chk("IxIx", s_xx, m_e.xx);
                    chk("IyIy", s_yy, m_e.yy);
                    chk("IxIy", s_xy, m_e.xy);
                    chk("IxIt", s_xt, m_e.xt);
                    chk("IyIt", s_yt, m_e.yt);
                    chk("latency", cyc - m_e.cyc, 3);
                    hold_e = m_e;
                end
            end else begin
                chk("hold_IxIx", s_xx, hold_e.xx);
                chk("hold_IyIt", s_yt, hold_e.yt);
                chk("hold_out_x", longint'(out_x), hold_e.x);
                chk("hold_out_y", longint'(out_y), hold_e.y);
            end
        end
    end

    function automatic exp_t model(input int x, input int y, input int mode);
        exp_t e;
        e = '{x: x, y: y, xx: 0, yy: 0, xy: 0, xt: 0, yt: 0, cyc: 0};
        if (mode == 1) begin
            e.xx = kc.xx; e.yy = kc.yy; e.xy = kc.xy; e.xt = kc.xt; e.yt = kc.yt;
        end else if (mode == 2) begin
            e.xx = (x >= 7 && x <= 11 && y >= 3 && y <= 7) ? 100 : 0;
        end else begin
            for (int dy = 0; dy < WN; dy++)
                for (int dx = 0; dx < WN; dx++) begin
                    int a, b, t;
                    a = gx[y-dy][x-dx]; b = gy[y-dy][x-dx]; t = gt[y-dy][x-dx];
                    e.xx += a * a; e.yy += b * b; e.xy += a * b; e.xt += a * t; e.yt += b * t;
                end
        end
        return e;
    endfunction

    task automatic fill_const(input int a, input int b, input int t);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                gx[y][x] = a; gy[y][x] = b; gt[y][x] = t;
            end
    endtask

    task automatic fill_rand();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                gx[y][x] = int'($urandom_range(0, 4095)) - 2048;
                gy[y][x] = int'($urandom_range(0, 4095)) - 2048;
                gt[y][x] = int'($urandom_range(0, 4095)) - 2048;
            end
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        grad_valid = 1'b0;
        sof = 1'($urandom_range(0, 1));
        grad_x = GW'($urandom); grad_y = GW'($urandom); grad_t = GW'($urandom);
    endtask

    task automatic send_partial(input int n, input int mode, input bit gaps);
        for (int i = 0; i < n; i++) begin
            int x, y;
            x = i % W;
            y = i / W;
            if (gaps) while ($urandom_range(0, 9) < 3) idle_cycle();
            @(posedge clk); #1;
            grad_valid = 1'b1;
            sof = (i == 0);
            grad_x = GW'(gx[y][x]); grad_y = GW'(gy[y][x]); grad_t = GW'(gt[y][x]);
            if (x >= WN - 1 && y >= WN - 1) begin
                exp_t e;
                e = model(x, y, mode);
                e.cyc = cyc;
                q.push_back(e);
            end
        end
    endtask

    task automatic drain();
        idle_cycle();
        sof = 1'b0;
        for (int i = 0; i < 40 && q.size() > 0; i++) @(posedge clk);
        chk("drain_empty", q.size(), 0);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: still running at time limit, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        hold_e = '{x: 0, y: 0, xx: 0, yy: 0, xy: 0, xt: 0, yt: 0, cyc: 0};
        kc = hold_e;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", longint'(accum_valid), 0);
        chk("reset_IxIx", s_xx, 0);
        chk("reset_out_x", longint'(out_x), 0);
        #1 rst_n = 1'b1;

        // constant frame immediately followed by an impulse frame, no dead cycles between
        pulses = 0;
        fill_const(1, 2, -1);
        kc = '{x: 0, y: 0, xx: 25, yy: 100, xy: 50, xt: -25, yt: -50, cyc: 0};
        send_partial(W * H, 1, 1'b0);
        fill_const(0, 0, 0);
        gx[3][7] = 10;
        send_partial(W * H, 2, 1'b0);
        drain();
        chk("pulses_two_frames", pulses, 96);

        pulses = 0;
        fill_const(-2048, -2048, -2048);
        kc = '{x: 0, y: 0, xx: 104857600, yy: 104857600, xy: 104857600, xt: 104857600, yt: 104857600, cyc: 0};
        send_partial(W * H, 1, 1'b0);
        drain();
        chk("pulses_min_grad", pulses, 48);

        pulses = 0;
        fill_rand();
        send_partial(W * H, 0, 1'b1);
        drain();
        chk("pulses_gaps", pulses, 48);

        // asynchronous reset while outputs are in flight
        fill_rand();
        send_partial(6 * W + 7, 0, 1'b1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        grad_valid = 1'b0;
        sof = 1'b0;
        q.delete();
        hold_e = '{x: 0, y: 0, xx: 0, yy: 0, xy: 0, xt: 0, yt: 0, cyc: 0};
        #1;
        chk("midrst_valid", longint'(accum_valid), 0);
        chk("midrst_IxIx", s_xx, 0);
        chk("midrst_IyIt", s_yt, 0);
        chk("midrst_out_y", longint'(out_y), 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        pulses = 0;
        fill_rand();
        send_partial(W * H, 0, 1'b1);
        drain();
        chk("pulses_after_reset", pulses, 48);

        // sof arrives at (9,2) of an unfinished frame
        pulses = 0;
        fill_rand();
        send_partial(2 * W + 9, 0, 1'b1);
        fill_rand();
        send_partial(W * H, 0, 1'b1);
        drain();
        chk("pulses_resync", pulses, 48);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
